sb_rx_deser: RTL and testbench

SB_RX_DESER -- requirements
Module: sb_rx_deser

---
 rtl/sb_pkg.sv | 13 +
 rtl/sb_rx_deser.sv | 205 ++++++++++++++++++++
 tb/tb_sb_rx_deser.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/sb_pkg.sv
// Shared constants and state encoding for the sideband serial-to-parallel receiver.
package sb_pkg;

  localparam int SB_PKT_W   = 64;
  localparam int SB_GAP_MIN = 32;

  typedef enum logic [1:0] {
    SB_IDLE  = 2'd0,
    SB_SHIFT = 2'd1,
    SB_GAP   = 2'd2
  } sb_deser_state_e;

endpackage

// File: rtl/sb_rx_deser.sv
// Sideband serial receiver: LSB-first deserializer with an output register and a one-entry skid.
// Define SB_DESER_GAP_CHECK_EN to build in the inter-packet gap tracker and o_gap_err.
module sb_rx_deser
  import sb_pkg::*;
#(
  parameter int PKT_W   = SB_PKT_W,
  parameter int GAP_MIN = SB_GAP_MIN
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ser_data,
  input  logic             i_ser_valid,
  input  logic             i_de_ser_done_sampled,
  output logic [PKT_W-1:0] o_deser_data,
  output logic             o_de_ser_done,
  output logic             o_busy,
  output logic             o_frame_err,
  output logic             o_overrun_err,
  output logic             o_gap_err
);

  localparam logic [6:0] LAST_CNT = 7'(PKT_W - 1);

  sb_deser_state_e  state_q, state_d;
  logic [6:0]       cnt_q, cnt_d;
  logic [PKT_W-2:0] shift_q, shift_d;
  logic [PKT_W-1:0] shift_in;
  logic             complete;

  logic             frame_err_q, frame_err_d;
  logic             overrun_err_q, overrun_err_d;

  logic [PKT_W-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             pend_q, pend_d;
  logic [PKT_W-1:0] skid_data_q, skid_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic             ack;

`ifdef SB_DESER_GAP_CHECK_EN
  localparam int GAP_W = $clog2(GAP_MIN + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_MIN - 1);

  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             gap_err_q, gap_err_d;
`endif

  // The newest bit enters at the top, so the first bit ends up in bit 0.
  assign shift_in = {i_ser_data, shift_q};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    complete    = 1'b0;
    frame_err_d = 1'b0;
`ifdef SB_DESER_GAP_CHECK_EN
    gap_cnt_d   = '0;
    gap_err_d   = 1'b0;
`endif

    case (state_q)
      SB_IDLE: begin
        if (i_ser_valid) begin
          shift_d = shift_in[PKT_W-1:1];
          cnt_d   = 7'd1;
          state_d = SB_SHIFT;
        end
      end

      SB_SHIFT: begin
        if (i_ser_valid) begin
          shift_d = shift_in[PKT_W-1:1];
          if (cnt_q == LAST_CNT) begin
            cnt_d    = 7'd0;
            complete = 1'b1;
`ifdef SB_DESER_GAP_CHECK_EN
            state_d  = SB_GAP;
`else
            state_d  = SB_IDLE;
`endif
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end else begin
          frame_err_d = 1'b1;
          cnt_d       = 7'd0;
          shift_d     = '0;
          state_d     = SB_IDLE;
        end
      end

`ifdef SB_DESER_GAP_CHECK_EN
      // An early restart is flagged but still taken as bit 0 of the next packet.
      SB_GAP: begin
        if (i_ser_valid) begin
          gap_err_d = 1'b1;
          shift_d   = shift_in[PKT_W-1:1];
          cnt_d     = 7'd1;
          state_d   = SB_SHIFT;
        end else if (gap_cnt_q == GAP_LAST) begin
          state_d = SB_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
`endif

      default: begin
        state_d = SB_IDLE;
        cnt_d   = 7'd0;
      end
    endcase
  end

  assign ack = i_de_ser_done_sampled & out_valid_q;

  // An ack always opens a one-cycle bubble; pend_q marks a packet parked in the output during it.
  always_comb begin
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q;
    pend_d        = 1'b0;
    skid_data_d   = skid_data_q;
    skid_valid_d  = skid_valid_q;
    overrun_err_d = 1'b0;

    if (pend_q) begin
      out_valid_d = 1'b1;
    end

    if (ack) begin
      out_valid_d = 1'b0;
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        pend_d       = 1'b1;
        skid_valid_d = complete;
        if (complete) begin
          skid_data_d = shift_in;
        end
      end else if (complete) begin
        out_data_d = shift_in;
        pend_d     = 1'b1;
      end
    end else if (complete) begin
      if (!out_valid_q && !pend_q) begin
        out_data_d  = shift_in;
        out_valid_d = 1'b1;
      end else if (!skid_valid_q) begin
        skid_data_d  = shift_in;
        skid_valid_d = 1'b1;
      end else begin
        overrun_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= SB_IDLE;
      cnt_q         <= 7'd0;
      shift_q       <= '0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      pend_q        <= 1'b0;
      skid_data_q   <= '0;
      skid_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shift_q       <= shift_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      pend_q        <= pend_d;
      skid_data_q   <= skid_data_d;
      skid_valid_q  <= skid_valid_d;
    end
  end

`ifdef SB_DESER_GAP_CHECK_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      gap_cnt_q <= '0;
      gap_err_q <= 1'b0;
    end else begin
      gap_cnt_q <= gap_cnt_d;
      gap_err_q <= gap_err_d;
    end
  end

  assign o_gap_err = gap_err_q;
`else
  assign o_gap_err = 1'b0;
`endif

  assign o_deser_data  = out_data_q;
  assign o_de_ser_done = out_valid_q;
  assign o_busy        = (state_q != SB_IDLE);
  assign o_frame_err   = frame_err_q;
  assign o_overrun_err = overrun_err_q;

endmodule

// File: tb/tb_sb_rx_deser.sv
// Directed bench for sb_rx_deser: table-driven packet/ack vectors plus hand-written corner sequences.
module tb_sb_rx_deser;
  import sb_pkg::*;

  localparam int PKT_W = SB_PKT_W;

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             i_ser_data = 1'b0;
  logic             i_ser_valid = 1'b0;
  logic             i_de_ser_done_sampled = 1'b0;
  logic [PKT_W-1:0] o_deser_data;
  logic             o_de_ser_done;
  logic             o_busy;
  logic             o_frame_err;
  logic             o_overrun_err;
  logic             o_gap_err;

  int checks = 0;
  int passes = 0;
  int frame_cnt = 0;
  int overrun_cnt = 0;
  int gap_cnt = 0;

  typedef struct {
    logic [PKT_W-1:0] data;
    int               ack_delay;
    logic [PKT_W-1:0] exp_data;
  } vec_t;

  vec_t vecs[4];

  sb_rx_deser dut (
    .i_clk                 (i_clk),
    .i_rst_n               (i_rst_n),
    .i_ser_data            (i_ser_data),
    .i_ser_valid           (i_ser_valid),
    .i_de_ser_done_sampled (i_de_ser_done_sampled),
    .o_deser_data          (o_deser_data),
    .o_de_ser_done         (o_de_ser_done),
    .o_busy                (o_busy),
    .o_frame_err           (o_frame_err),
    .o_overrun_err         (o_overrun_err),
    .o_gap_err             (o_gap_err)
  );

  always #5 i_clk = ~i_clk;

  // Error pulses are tallied on the falling edge, one count per high cycle.
  always @(negedge i_clk) begin
    if (o_frame_err)   frame_cnt++;
    if (o_overrun_err) overrun_cnt++;
    if (o_gap_err)     gap_cnt++;
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    i_ser_valid = 1'b0;
    i_ser_data  = 1'b0;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic applyStimulus(input logic [PKT_W-1:0] d, input int nbits, input bit ack_last);
    for (int i = 0; i < nbits; i++) begin
      i_ser_valid = 1'b1;
      i_ser_data  = d[i];
      if (ack_last && (i == nbits - 1)) i_de_ser_done_sampled = 1'b1;
      step();
    end
    i_ser_valid           = 1'b0;
    i_ser_data            = 1'b0;
    i_de_ser_done_sampled = 1'b0;
  endtask

  task automatic ackCycle();
    i_de_ser_done_sampled = 1'b1;
    step();
    i_de_ser_done_sampled = 1'b0;
  endtask

  logic [PKT_W-1:0] p1, p2, p3;
  int fsnap, osnap, gsnap;
  int exp_gap;

  initial begin
    vecs[0] = '{data: 64'hA5A5_0000_FFFF_1234, ack_delay: 3, exp_data: 64'hA5A5_0000_FFFF_1234};
    vecs[1] = '{data: 64'hFFFF_FFFF_FFFF_FFFF, ack_delay: 1, exp_data: 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[2] = '{data: 64'h5555_AAAA_0F0F_F0F0, ack_delay: 5, exp_data: 64'h5555_AAAA_0F0F_F0F0};
    vecs[3] = '{data: 64'h0000_0000_0000_0001, ack_delay: 2, exp_data: 64'h0000_0000_0000_0001};

    #12;
    checkOutput("reset_outputs",
                {o_deser_data, o_de_ser_done, o_busy, o_frame_err, o_overrun_err, o_gap_err}, '0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    step();

    for (int v = 0; v < 4; v++) begin
      applyStimulus(vecs[v].data, PKT_W, 1'b0);
      checkOutput($sformatf("v%0d_done_latency", v), o_de_ser_done, 1'b1);
      checkOutput($sformatf("v%0d_data", v), o_deser_data, vecs[v].exp_data);
      for (int j = 0; j < vecs[v].ack_delay - 1; j++) idle(1);
      checkOutput($sformatf("v%0d_data_hold", v), {o_de_ser_done, o_deser_data}, {1'b1, vecs[v].exp_data});
      ackCycle();
      checkOutput($sformatf("v%0d_done_clear", v), o_de_ser_done, 1'b0);
      idle(32 - vecs[v].ack_delay);
      checkOutput($sformatf("v%0d_idle_busy", v), o_busy, 1'b0);
    end

    // Truncated packet, then a clean one.
    fsnap = frame_cnt;
    applyStimulus(64'hDEAD_BEEF_CAFE_F00D, 40, 1'b0);
    idle(3);
    checkOutput("frame_err_pulses", frame_cnt - fsnap, 1);
    checkOutput("frame_no_done", {o_de_ser_done, o_busy}, 2'b00);
    p1 = 64'h0123_4567_89AB_CDEF;
    applyStimulus(p1, PKT_W, 1'b0);
    checkOutput("frame_next_pkt", {o_de_ser_done, o_deser_data}, {1'b1, p1});
    ackCycle();
    idle(32);

    // Three packets without ack: output, skid, drop.
    p1 = 64'h1111_2222_3333_4444;
    p2 = 64'h5555_6666_7777_8888;
    p3 = 64'h9999_AAAA_BBBB_CCCC;
    osnap = overrun_cnt;
    applyStimulus(p1, PKT_W, 1'b0);
    idle(32);
    applyStimulus(p2, PKT_W, 1'b0);
    idle(32);
    applyStimulus(p3, PKT_W, 1'b0);
    idle(32);
    checkOutput("overrun_pulses", overrun_cnt - osnap, 1);
    checkOutput("overrun_hold_p1", {o_de_ser_done, o_deser_data}, {1'b1, p1});
    ackCycle();
    checkOutput("skid_bubble", o_de_ser_done, 1'b0);
    step();
    checkOutput("skid_p2", {o_de_ser_done, o_deser_data}, {1'b1, p2});
    ackCycle();
    checkOutput("skid_ack_clear", o_de_ser_done, 1'b0);
    step();
    checkOutput("skid_empty", o_de_ser_done, 1'b0);
    idle(4);

    // Restart only 10 idle cycles after completion.
`ifdef SB_DESER_GAP_CHECK_EN
    exp_gap = 1;
`else
    exp_gap = 0;
`endif
    p1 = 64'hF00D_0000_1234_5678;
    p2 = 64'h8765_4321_0000_BEEF;
    gsnap = gap_cnt;
    applyStimulus(p1, PKT_W, 1'b0);
    idle(1);
    ackCycle();
    idle(8);
    applyStimulus(p2, PKT_W, 1'b0);
    idle(1);
    checkOutput("gap_err_pulses", gap_cnt - gsnap, exp_gap);
    checkOutput("gap_pkt_received", {o_de_ser_done, o_deser_data}, {1'b1, p2});
    idle(31);

    // Completion on the same edge as the ack of the held packet.
    p3 = 64'hC0DE_C0DE_1357_9BDF;
    osnap = overrun_cnt;
    applyStimulus(p3, PKT_W, 1'b1);
    checkOutput("simul_bubble", o_de_ser_done, 1'b0);
    step();
    checkOutput("simul_new_data", {o_de_ser_done, o_deser_data}, {1'b1, p3});
    checkOutput("simul_no_overrun", overrun_cnt - osnap, 0);
    idle(32);

    // Reset at bit 30 while a packet is still held unacked.
    p1 = 64'hAAAA_5555_AAAA_5555;
    for (int i = 0; i < 30; i++) begin
      i_ser_valid = 1'b1;
      i_ser_data  = p1[i];
      step();
    end
    checkOutput("pre_reset_busy", {o_de_ser_done, o_busy}, 2'b11);
    i_rst_n = 1'b0;
    #1;
    checkOutput("async_reset_outputs",
                {o_deser_data, o_de_ser_done, o_busy, o_frame_err, o_overrun_err, o_gap_err}, '0);
    i_ser_valid = 1'b0;
    i_ser_data  = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    step();
    fsnap = frame_cnt;
    osnap = overrun_cnt;
    gsnap = gap_cnt;
    p2 = 64'h0F1E_2D3C_4B5A_6978;
    applyStimulus(p2, PKT_W, 1'b0);
    checkOutput("post_reset_pkt", {o_de_ser_done, o_deser_data}, {1'b1, p2});
    idle(3);
    checkOutput("post_reset_no_err",
                {32'(frame_cnt - fsnap), 32'(overrun_cnt - osnap), 32'(gap_cnt - gsnap)}, '0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
